// File: rtl/wishbone_lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit: access sizes, fault
// causes, FSM states and the pre-bus legality check.
package wishbone_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_MISALIGN = 3'd1,
        CAUSE_BUS_ERR  = 3'd2,
        CAUSE_TIMEOUT  = 3'd3,
        CAUSE_RETRY    = 3'd4,
        CAUSE_ILL_SIZE = 3'd5
    } cause_e;

    // ST_GAP is the single idle cycle between a retry response and the reissue.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Faults that are known before any bus cycle is started.
    function automatic cause_e pre_bus_cause(input logic [1:0] size, input logic [1:0] addr_lo);
        cause_e c;
        c = CAUSE_NONE;
        case (size)
            2'b11:   c = CAUSE_ILL_SIZE;
            2'b01:   if (addr_lo[0]) c = CAUSE_MISALIGN;
            2'b10:   if (addr_lo != 2'b00) c = CAUSE_MISALIGN;
            default: c = CAUSE_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wishbone_lsu_if.sv
// Wishbone classic bus bundle between the load/store unit (master) and the
// SoC interconnect (slave).
//
// Handshake: a transfer is offered while cyc_o and stb_o are both high, with
// adr_o/sel_o/we_o/dat_o stable for the whole offer. The slave ends the offer
// with ack_i, err_i or rty_i in one cycle (err_i beats rty_i beats ack_i when
// several are high). The master drops cyc_o/stb_o in the cycle after any
// termination, so a slave never sees a second strobe for the same response.
// dat_i carries meaning only in the cycle where ack_i is high.
interface wishbone_lsu_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/wishbone_lsu_lane_align.sv
// Combinational byte-lane steering: byte-select and replicated write data
// for stores, lane extraction plus sign/zero extension for loads.
module wishbone_lsu_lane_align
    import wishbone_lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdat_o,
    output logic [31:0] load_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Select lanes and replicate right-aligned store data across the word.
    always_comb begin
        sel_o  = 4'b0000;
        wdat_o = 32'h0;
        case (size_i)
            SIZE_BYTE: begin
                sel_o  = 4'b0001 << addr_lo_i;
                wdat_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                sel_o  = 4'b0011 << addr_lo_i;
                wdat_o = {2{wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                sel_o  = 4'b1111;
                wdat_o = wdata_i;
            end
            default: begin
                sel_o  = 4'b0000;
                wdat_o = 32'h0;
            end
        endcase
    end

    // Pick the addressed lane out of the bus word and extend it to 32 bits.
    always_comb begin
        rd_byte = rd_word_i[{addr_lo_i, 3'b000} +: 8];
        rd_half = rd_word_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (size_i)
            SIZE_BYTE: load_o = unsigned_i ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SIZE_HALF: load_o = unsigned_i ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default:   load_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/wishbone_lsu.sv
// Load/store unit: turns one core byte/half/word access into a single
// Wishbone classic cycle, with retry, timeout and fault reporting.
module wishbone_lsu
    import wishbone_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [2:0]  fault_cause_o,
    output logic [1:0]  dbg_state_o,
    wishbone_lsu_if.master wb
);

    localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        fault_q, fault_d;
    cause_e      cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;

    cause_e      pre_cause;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdat;
    logic [31:0] lane_load;
    logic        in_bus;

    assign pre_cause = pre_bus_cause(size_i, addr_i[1:0]);

    wishbone_lsu_lane_align u_lane_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rd_word_i  (wb.dat_i),
        .sel_o      (lane_sel),
        .wdat_o     (lane_wdat),
        .load_o     (lane_load)
    );

    // Bus outputs are gated by the BUS state so the bus is quiet otherwise.
    assign in_bus    = (state_q == ST_BUS);
    assign wb.cyc_o  = in_bus;
    assign wb.stb_o  = in_bus;
    assign wb.we_o   = in_bus & we_q;
    assign wb.adr_o  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign wb.sel_o  = in_bus ? lane_sel : 4'b0000;
    assign wb.dat_o  = in_bus ? lane_wdat : 32'h0;

    assign done_o        = (state_q == ST_DONE);
    assign busy_o        = (state_q == ST_BUS) || (state_q == ST_GAP);
    assign fault_o       = done_o & fault_q;
    assign fault_cause_o = done_o ? cause_q : CAUSE_NONE;
    assign rdata_o       = done_o ? rdata_q : 32'h0;
    assign dbg_state_o   = state_q;

    // Next-state logic: request capture, bus termination handling, counters.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        retry_d = retry_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        cause_d = cause_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    size_d  = size_e'(size_i);
                    uns_d   = unsigned_i;
                    wdata_d = wdata_i;
                    retry_d = '0;
                    wait_d  = '0;
                    rdata_d = 32'h0;
                    cause_d = pre_cause;
                    fault_d = (pre_cause != CAUSE_NONE);
                    state_d = (pre_cause != CAUSE_NONE) ? ST_DONE : ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb.err_i) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_BUS_ERR;
                    state_d = ST_DONE;
                end else if (wb.rty_i) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_RETRY;
                        state_d = ST_DONE;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        wait_d  = '0;
                        state_d = ST_GAP;
                    end
                end else if (wb.ack_i) begin
                    rdata_d = we_q ? 32'h0 : lane_load;
                    state_d = ST_DONE;
                end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_GAP:  state_d = ST_BUS;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            retry_q <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            retry_q <= retry_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_wishbone_lsu.sv
// Bench for wishbone_lsu: a 16 KiB memory slave at address 0 with optional
// retry / err+ack behaviour, and a byte-array reference model of memory.
`timescale 1ns/1ps
module tb_wishbone_lsu;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAX_RETRY      = 3;
    localparam int MEM_BYTES      = 16384;
    localparam int BUDGET         = 200;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic [2:0]  fault_cause_o;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    wishbone_lsu_if wb();

    wishbone_lsu #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .size_i        (size_i),
        .unsigned_i    (unsigned_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .dbg_state_o   (dbg_state),
        .wb            (wb)
    );

    // clock
    always #5 clk_i = ~clk_i;

    // ---------------- slave / dummy responder ----------------
    int          resp_mode = 0;  // 0 memory (with rty_limit retries first), 1 err+ack
    int          rty_limit = 0;
    int          rty_given;
    logic [31:0] slv_mem [int];
    int          slv_idx;
    logic [31:0] slv_word;

    // One wait state: respond in the cycle after the strobe is first seen.
    always @(posedge clk_i) begin
        wb.ack_i <= 1'b0;
        wb.err_i <= 1'b0;
        wb.rty_i <= 1'b0;
        wb.dat_i <= 32'h0;
        if (rst_i) begin
            rty_given <= 0;
        end else begin
            if (done_o) rty_given <= 0;
            if (wb.cyc_o && wb.stb_o && !(wb.ack_i || wb.err_i || wb.rty_i)
                && wb.adr_o < MEM_BYTES) begin
                if (resp_mode == 1) begin
                    wb.err_i <= 1'b1;
                    wb.ack_i <= 1'b1;
                end else if (rty_given < rty_limit) begin
                    wb.rty_i  <= 1'b1;
                    rty_given <= rty_given + 1;
                end else begin
                    wb.ack_i <= 1'b1;
                    slv_idx  = int'(wb.adr_o[13:2]);
                    slv_word = slv_mem.exists(slv_idx) ? slv_mem[slv_idx] : 32'h0;
                    if (wb.we_o) begin
                        for (int j = 0; j < 4; j++)
                            if (wb.sel_o[j]) slv_word[8*j +: 8] = wb.dat_o[8*j +: 8];
                        slv_mem[slv_idx] = slv_word;
                    end else begin
                        wb.dat_i <= slv_word;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] model_mem [int];

    function automatic int nbytes_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] model_rd(input int a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    function automatic logic [2:0] exp_cause(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 3'd5;
        if ((a % nbytes_of(s)) != 0) return 3'd1;
        if (a >= MEM_BYTES) return 3'd3;
        if (resp_mode == 1) return 3'd2;
        if (rty_limit > MAX_RETRY) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] s, input logic [31:0] a, input logic u);
        logic [31:0] v;
        int n;
        n = nbytes_of(s);
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = model_rd(int'(a) + k);
        if (!u && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one access, watch it to completion and compare against the model.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                             output logic [31:0] o_rdata, output logic [3:0] o_sel,
                             output logic [31:0] o_dat, output int o_lat);
        int lat, cyc_cnt, issues, viol, n, a;
        logic prev_cyc, got, got_fault;
        logic [2:0] got_cause, ec;
        logic [3:0] seen_sel, esel;
        logic [31:0] seen_dat, seen_adr, got_rdata, edat;
        logic seen_we;
        lat = 1; cyc_cnt = 0; issues = 0; viol = 0; prev_cyc = 1'b0; got = 1'b0;
        seen_sel = 4'h0; seen_dat = 32'h0; seen_adr = 32'h0; seen_we = 1'b0;
        got_rdata = 32'h0; got_fault = 1'b0; got_cause = 3'd0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; size_i = size; unsigned_i = uns; wdata_i = wdata;
        @(negedge clk_i);
        req_i = 1'b0;
        while (1) begin
            if (wb.cyc_o) begin
                cyc_cnt++;
                if (!prev_cyc) issues++;
                seen_sel = wb.sel_o; seen_dat = wb.dat_o; seen_adr = wb.adr_o; seen_we = wb.we_o;
            end
            if (wb.cyc_o !== wb.stb_o) viol++;
            if (busy_o !== !done_o) viol++;
            if (!done_o && (rdata_o !== 32'h0 || fault_o !== 1'b0)) viol++;
            prev_cyc = wb.cyc_o;
            if (done_o) begin
                got = 1'b1; got_rdata = rdata_o; got_fault = fault_o; got_cause = fault_cause_o;
                break;
            end
            if (lat >= BUDGET) break;
            @(negedge clk_i);
            lat++;
        end
        ec = exp_cause(size, addr);
        n  = nbytes_of(size);
        a  = int'(addr);
        check({tag, ":done_seen"}, 32'(got), 32'd1);
        check({tag, ":cause"}, 32'(got_cause), 32'(ec));
        check({tag, ":fault"}, 32'(got_fault), 32'(ec != 3'd0));
        check({tag, ":protocol"}, 32'(viol), 32'd0);
        if (ec == 3'd0) begin
            esel = 4'h0;
            edat = 32'h0;
            for (int k = 0; k < n; k++) esel[(a % 4) + k] = 1'b1;
            for (int j = 0; j < 4; j++) edat[8*j +: 8] = wdata[8*(j % n) +: 8];
            check({tag, ":latency"}, 32'(lat), 32'(3 + 3 * rty_limit));
            check({tag, ":issues"}, 32'(issues), 32'(rty_limit + 1));
            check({tag, ":sel"}, 32'(seen_sel), 32'(esel));
            check({tag, ":adr"}, seen_adr, {addr[31:2], 2'b00});
            check({tag, ":we"}, 32'(seen_we), 32'(we));
            if (we) begin
                check({tag, ":dat_o"}, seen_dat, edat);
                check({tag, ":rdata_st"}, got_rdata, 32'h0);
                for (int k = 0; k < n; k++) model_mem[a + k] = wdata[8*k +: 8];
            end else begin
                check({tag, ":rdata"}, got_rdata, exp_load(size, addr, uns));
            end
        end else begin
            check({tag, ":rdata_fault"}, got_rdata, 32'h0);
            if (ec == 3'd1 || ec == 3'd5) begin
                check({tag, ":latency"}, 32'(lat), 32'd1);
                check({tag, ":no_cyc"}, 32'(cyc_cnt), 32'd0);
            end else if (ec == 3'd3) begin
                check({tag, ":cyc_cycles"}, 32'(cyc_cnt), 32'(TIMEOUT_CYCLES));
                check({tag, ":latency"}, 32'(lat), 32'(TIMEOUT_CYCLES + 1));
            end else if (ec == 3'd2) begin
                check({tag, ":latency"}, 32'(lat), 32'd3);
                check({tag, ":issues"}, 32'(issues), 32'd1);
            end else begin
                check({tag, ":issues"}, 32'(issues), 32'(MAX_RETRY + 1));
                check({tag, ":latency"}, 32'(lat), 32'(3 + 3 * MAX_RETRY));
            end
        end
        o_rdata = got_rdata; o_sel = seen_sel; o_dat = seen_dat; o_lat = lat;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd, dt;
        logic [3:0]  sl;
        int          lt, dn_cnt;
        logic [1:0]  rs;
        logic [31:0] ra;

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0;
        size_i = 2'b00; unsigned_i = 1'b0; wdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        check("reset:cyc", 32'(wb.cyc_o), 32'd0);
        check("reset:stb", 32'(wb.stb_o), 32'd0);
        check("reset:outs", {busy_o, done_o, fault_o, fault_cause_o, 26'h0}, 32'h0);
        check("reset:rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle:cyc", 32'(wb.cyc_o), 32'd0);

        do_access("sw", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, sl, dt, lt);
        check("sw:sel_const", 32'(sl), 32'hF);
        check("sw:lat_const", 32'(lt), 32'd3);
        do_access("lw", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, sl, dt, lt);
        check("lw:rdata_const", rd, 32'hDEADBEEF);
        check("lw:lat_const", 32'(lt), 32'd3);
        do_access("sb", 1'b1, 32'h13, 2'b00, 1'b0, 32'h80, rd, sl, dt, lt);
        check("sb:sel_const", 32'(sl), 32'h8);
        check("sb:dat_const", dt, 32'h80808080);
        do_access("lb", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, sl, dt, lt);
        check("lb:rdata_const", rd, 32'hFFFFFF80);
        do_access("lbu", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, sl, dt, lt);
        check("lbu:rdata_const", rd, 32'h00000080);
        do_access("lh_mis", 1'b0, 32'h11, 2'b01, 1'b0, 32'h0, rd, sl, dt, lt);
        do_access("ill_size", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, sl, dt, lt);
        do_access("unmapped", 1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'h0, rd, sl, dt, lt);

        rty_limit = 2;
        do_access("rty2", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, sl, dt, lt);
        check("rty2:rdata_const", rd, 32'h80ADBEEF);
        rty_limit = MAX_RETRY + 1;
        do_access("rty_fault", 1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678, rd, sl, dt, lt);
        rty_limit = 0;
        resp_mode = 1;
        do_access("err_ack", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, sl, dt, lt);
        resp_mode = 0;

        // Reset two cycles into an access to an address that never responds.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8000_0000; size_i = 2'b10;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid:cyc_before", 32'(wb.cyc_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid:cyc_after", 32'(wb.cyc_o), 32'd0);
        dn_cnt = 0;
        if (done_o) dn_cnt++;
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (done_o || wb.cyc_o) dn_cnt++;
        end
        check("rst_mid:quiet", 32'(dn_cnt), 32'd0);
        do_access("after_rst", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, sl, dt, lt);

        // Random accesses in a small mapped window, some with retries.
        for (int i = 0; i < 40; i++) begin
            rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ra = 32'($urandom_range(0, 63));
            rty_limit = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAX_RETRY + 1) : 0;
            do_access("rand", 1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)),
                      $urandom, rd, sl, dt, lt);
        end
        rty_limit = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
